// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit sitting between the core datapath and a
// request/ready memory bus. Stalls the core while an access is outstanding,
// formats store lanes/byte enables and sign/zero-extends load data.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  AccessFault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;

  logic        access;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] load_q;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  // Decode the incoming request: fault detection and store lane formatting
  always_comb begin
    access = MemRead | MemWrite;
    if (MemWrite) begin
      illegal = Funct3[2] | (Funct3[1:0] == 2'b11);
    end else begin
      illegal = (Funct3 == 3'b011) | (Funct3 == 3'b110) | (Funct3 == 3'b111);
    end
    misaligned = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((Funct3 == 3'b010) & (ALUResult[1:0] != 2'b00));
    fault = access & (illegal | misaligned);

    be_d    = 4'b1111;
    wdata_d = '0;
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << ALUResult[1:0];
          wdata_d = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteData[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = WriteData;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    case (offset_q)
      2'b00:   lane_byte = mem_rdata[7:0];
      2'b01:   lane_byte = mem_rdata[15:8];
      2'b10:   lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_fmt = {24'd0, lane_byte};
      3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_fmt = {16'd0, lane_half};
      default: load_fmt = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access && !fault) state_next = BUSY;
      BUSY:    if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches (held stable on the bus while BUSY) and load capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      funct3_q  <= '0;
      offset_q  <= '0;
      load_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !fault) begin
            mem_we    <= MemWrite;
            mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            funct3_q  <= Funct3;
            offset_q  <= ALUResult[1:0];
          end
        end
        BUSY: begin
          if (mem_ready && !mem_we) load_q <= load_fmt;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    mem_req     = 1'b0;
    Stall       = 1'b0;
    AccessFault = 1'b0;
    ReadData    = '0;
    case (state)
      IDLE: begin
        Stall       = access & ~fault;
        AccessFault = fault;
      end
      BUSY: begin
        mem_req = 1'b1;
        Stall   = 1'b1;
      end
      DONE: begin
        ReadData = load_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of accesses with expected
// bus fields, a queue of expected ReadData values popped when the unit
// retires, and hand-written reset / idle-ready sequences.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessFault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int unsigned busy;
    logic        flt;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  logic [31:0] last_load;
  int unsigned n_checks;
  int unsigned n_fail;

  function automatic vec_t mk(string n, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rdat,
                              int unsigned busy, logic flt, logic [31:0] ea,
                              logic [3:0] ebe, logic [31:0] ewd, logic ewe,
                              logic [31:0] erd);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd;
    v.rdata = rdat; v.busy = busy; v.flt = flt; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_we = ewe; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned stall_cnt;
    logic [31:0] exp_rd;
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wd; mem_ready = 1'b0;
    #1;
    if (v.flt) begin
      chk({v.name, " fault"},         32'(AccessFault), 32'd1);
      chk({v.name, " fault stall"},   32'(Stall),       32'd0);
      chk({v.name, " fault req"},     32'(mem_req),     32'd0);
      chk({v.name, " fault rdata"},   ReadData,         32'd0);
      @(negedge clk);
      #1;
      chk({v.name, " fault req+1"},   32'(mem_req),     32'd0);
      chk({v.name, " fault held"},    32'(AccessFault), 32'd1);
      chk({v.name, " fault stall+1"}, 32'(Stall),       32'd0);
      MemRead = 1'b0; MemWrite = 1'b0;
    end else begin
      chk({v.name, " no fault"},  32'(AccessFault), 32'd0);
      chk({v.name, " stall idle"}, 32'(Stall),      32'd1);
      chk({v.name, " req idle"},  32'(mem_req),     32'd0);
      stall_cnt = 1;
      if (v.wr) begin
        sb_q.push_back(last_load);
      end else begin
        sb_q.push_back(v.e_rd);
        last_load = v.e_rd;
      end
      for (int unsigned i = 0; i < v.busy; i++) begin
        @(negedge clk);
        // scramble core inputs: the latched request must be used
        MemRead = 1'b1; MemWrite = 1'($urandom); Funct3 = 3'($urandom);
        ALUResult = $urandom; WriteData = $urandom;
        #1;
        chk({v.name, " req"},   32'(mem_req),   32'd1);
        chk({v.name, " addr"},  mem_addr,       v.e_addr);
        chk({v.name, " be"},    32'(mem_be),    32'(v.e_be));
        chk({v.name, " wdata"}, mem_wdata,      v.e_wdata);
        chk({v.name, " we"},    32'(mem_we),    32'(v.e_we));
        if (Stall) stall_cnt++;
        mem_ready = (i == v.busy - 1);
        mem_rdata = mem_ready ? v.rdata : $urandom;
      end
      @(negedge clk);
      mem_ready = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk({v.name, " done stall"}, 32'(Stall),   32'd0);
      chk({v.name, " done req"},   32'(mem_req), 32'd0);
      if (sb_q.size() == 0) begin
        chk({v.name, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
        exp_rd = sb_q.pop_front();
        chk({v.name, " rdata"}, ReadData, exp_rd);
      end
      chk({v.name, " stall cycles"}, 32'(stall_cnt), 32'(1 + v.busy));
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " req"},   32'(mem_req),     32'd0);
    chk({nm, " stall"}, 32'(Stall),       32'd0);
    chk({nm, " rdata"}, ReadData,         32'd0);
    chk({nm, " fault"}, 32'(AccessFault), 32'd0);
    chk({nm, " addr"},  mem_addr,         32'd0);
    chk({nm, " be"},    32'(mem_be),      32'd0);
    chk({nm, " wdata"}, mem_wdata,        32'd0);
    chk({nm, " we"},    32'(mem_we),      32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; last_load = '0;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    ALUResult = '0; WriteData = '0; mem_ready = 1'b0; mem_rdata = '0;

    //            name      rd wr f3      addr          wd            rdata         bsy flt  e_addr        e_be     e_wdata       we  e_rd
    vecs.push_back(mk("LW",    1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk("LB",    1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 0, 32'h100, 4'b1111, 32'h0,        0, 32'hFFFFFF80));
    vecs.push_back(mk("LBU",   1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 2, 0, 32'h100, 4'b1111, 32'h0,        0, 32'h00000080));
    vecs.push_back(mk("LH",    1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 2, 0, 32'h100, 4'b1111, 32'h0,        0, 32'hFFFF8001));
    vecs.push_back(mk("LHU",   1, 0, 3'b101, 32'h102, 32'h0,        32'h80011234, 1, 0, 32'h100, 4'b1111, 32'h0,        0, 32'h00008001));
    vecs.push_back(mk("LBpos", 1, 0, 3'b000, 32'h101, 32'h0,        32'h12347F56, 3, 0, 32'h100, 4'b1111, 32'h0,        0, 32'h0000007F));
    vecs.push_back(mk("LHlo",  1, 0, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 1, 0, 32'h100, 4'b1111, 32'h0,        0, 32'hFFFFF00D));
    vecs.push_back(mk("SB",    0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h0,        5, 0, 32'h200, 4'b0010, 32'hABABABAB, 1, 32'h0));
    vecs.push_back(mk("SH",    0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        1, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 1, 32'h0));
    vecs.push_back(mk("SW",    0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        2, 0, 32'h204, 4'b1111, 32'hCAFEF00D, 1, 32'h0));
    vecs.push_back(mk("SBhi",  0, 1, 3'b000, 32'h203, 32'h00000055, 32'h0,        1, 0, 32'h200, 4'b1000, 32'h55555555, 1, 32'h0));
    vecs.push_back(mk("SHlo",  0, 1, 3'b001, 32'h200, 32'h12345678, 32'h0,        1, 0, 32'h200, 4'b0011, 32'h56785678, 1, 32'h0));
    vecs.push_back(mk("RWboth",1, 1, 3'b000, 32'h202, 32'h00000077, 32'h0,        1, 0, 32'h200, 4'b0100, 32'h77777777, 1, 32'h0));
    vecs.push_back(mk("fLW",   1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("fLH",   1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("fL011", 1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("fLHU",  1, 0, 3'b101, 32'h103, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("fSW",   0, 1, 3'b010, 32'h201, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("fS100", 0, 1, 3'b100, 32'h200, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        0, 32'h0));
    vecs.push_back(mk("LWend", 1, 0, 3'b010, 32'h104, 32'h0,        32'h0BADF00D, 1, 0, 32'h104, 4'b1111, 32'h0,        0, 32'h0BADF00D));

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    // A stray mem_ready while idle must not start or retire anything
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("idle ready req",   32'(mem_req), 32'd0);
    chk("idle ready stall", 32'(Stall),   32'd0);
    chk("idle ready rdata", ReadData,     32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset held for two cycles while a load is outstanding
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
    repeat (2) @(negedge clk);
    #1;
    chk("abort req busy", 32'(mem_req), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_state("abort rst1");
    @(negedge clk);
    #1;
    chk_reset_state("abort rst2");
    reset = 1'b0;
    last_load = '0;
    @(negedge clk);
    #1;
    chk("abort after req",   32'(mem_req), 32'd0);
    chk("abort after stall", 32'(Stall),   32'd0);

    // Recovery: a store retires with the cleared load register, then a load
    run_vec(mk("SBpost", 0, 1, 3'b000, 32'h402, 32'h000000C3, 32'h0, 1, 0, 32'h400, 4'b0100, 32'hC3C3C3C3, 1, 32'h0));
    run_vec(mk("LHpost", 1, 0, 3'b001, 32'h402, 32'h0, 32'h7FFE0000, 2, 0, 32'h400, 4'b1111, 32'h0, 0, 32'h00007FFE));

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
